// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and saturation helper for seq_alu_unit.
package seq_alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Per-bit clamp: on overflow the bit is forced to the clamp level.
   function automatic logic sat_bit(input logic value_bit, input logic ovf, input logic clamp_hi);
      logic res;
      if (ovf) begin
         res = clamp_hi;
      end else begin
         res = value_bit;
      end
      return res;
   endfunction

endpackage

// File: rtl/seq_alu_mul_core.sv
// Iterative shift-add multiplier: one partial-product step per cycle, DATA_W steps.
module seq_alu_mul_core
   import seq_alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [DATA_W-1:0]     i_a,
   input  logic [DATA_W-1:0]     i_b,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [2*DATA_W-1:0]   o_product
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   logic [2*DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0]   r_mplier;
   logic [2*DATA_W-1:0] r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic [2*DATA_W-1:0] w_acc_nxt;

   // o_done flags the final step so the product already includes that step's partial product.
   always_comb begin
      w_acc_nxt = r_acc;
      if (r_mplier[0]) begin
         w_acc_nxt = r_acc + r_mcand;
      end else begin
         w_acc_nxt = r_acc;
      end
   end

   assign o_busy    = (r_cnt != {CNT_W{1'b0}});
   assign o_done    = (r_cnt == CNT_W'(1));
   assign o_product = w_acc_nxt;

   // Operand load on start, then one shift-add step per cycle until the counter drains.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mcand  <= {(2*DATA_W){1'b0}};
         r_mplier <= {DATA_W{1'b0}};
         r_acc    <= {(2*DATA_W){1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
      end else if (i_start) begin
         r_mcand  <= {{DATA_W{1'b0}}, i_a};
         r_mplier <= i_b;
         r_acc    <= {(2*DATA_W){1'b0}};
         r_cnt    <= CNT_W'(DATA_W);
      end else if (o_busy) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt - CNT_W'(1);
      end else begin
         r_acc    <= r_acc;
      end
   end

endmodule

// File: rtl/seq_alu_unit.sv
// Registered add/sub/multiply unit with valid/ready handshake on both sides.
// Optional saturation: define SEQ_ALU_SAT_EN to clamp results instead of widening/wrapping.
module seq_alu_unit
   import seq_alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [1:0]            i_op,
   input  logic [DATA_W-1:0]     i_value_a,
   input  logic [DATA_W-1:0]     i_value_b,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [2*DATA_W-1:0]   o_result,
   output logic                  o_carry,
   output logic                  o_zero,
   output logic                  o_err
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [2*DATA_W-1:0] r_result;
   logic                r_carry;
   logic                r_zero;
   logic                r_err;

   logic                w_load;
   logic [2*DATA_W-1:0] w_res_nxt;
   logic                w_carry_nxt;
   logic                w_err_nxt;
   logic                w_mul_start;
   logic                w_mul_busy;
   logic                w_mul_done;
   logic [2*DATA_W-1:0] w_product;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W-1:0]   w_diff;
   logic                w_borrow;
   logic                w_mul_ovf;
   logic [2*DATA_W-1:0] w_add_res;
   logic [2*DATA_W-1:0] w_sub_res;
   logic [2*DATA_W-1:0] w_mul_res;

   assign o_ready     = (r_state == ST_IDLE);
   assign o_valid     = (r_state == ST_DONE);
   assign o_result    = r_result;
   assign o_carry     = r_carry;
   assign o_zero      = r_zero;
   assign o_err       = r_err;

   assign w_sum       = {1'b0, i_value_a} + {1'b0, i_value_b};
   assign w_diff      = i_value_a - i_value_b;
   assign w_borrow    = (i_value_a < i_value_b);
   assign w_mul_ovf   = |w_product[2*DATA_W-1:DATA_W];
   assign w_mul_start = i_valid && o_ready && (i_op == OP_MUL);

   seq_alu_mul_core #(.DATA_W(DATA_W)) u_mul_core (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (w_mul_start),
      .i_a       (i_value_a),
      .i_b       (i_value_b),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   // Candidate results per operation, clamped or full-width depending on build.
   always_comb begin
      w_add_res = {(2*DATA_W){1'b0}};
      w_sub_res = {(2*DATA_W){1'b0}};
      w_mul_res = {(2*DATA_W){1'b0}};
`ifdef SEQ_ALU_SAT_EN
      for (int k = 0; k < DATA_W; k++) begin
         w_add_res[k] = sat_bit(w_sum[k], w_sum[DATA_W], 1'b1);
         w_sub_res[k] = sat_bit(w_diff[k], w_borrow, 1'b0);
         w_mul_res[k] = sat_bit(w_product[k], w_mul_ovf, 1'b1);
      end
`else
      w_add_res = {{(DATA_W-1){1'b0}}, w_sum};
      w_sub_res = {{DATA_W{1'b0}}, w_diff};
      w_mul_res = w_product;
`endif
   end

   // Next-state and result-load decode.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_res_nxt   = r_result;
      w_carry_nxt = r_carry;
      w_err_nxt   = r_err;
      case (r_state)
         ST_IDLE: begin
            if (i_valid) begin
               case (i_op)
                  OP_ADD: begin
                     w_load      = 1'b1;
                     w_res_nxt   = w_add_res;
                     w_carry_nxt = w_sum[DATA_W];
                     w_err_nxt   = 1'b0;
                     w_state_nxt = ST_DONE;
                  end
                  OP_SUB: begin
                     w_load      = 1'b1;
                     w_res_nxt   = w_sub_res;
                     w_carry_nxt = w_borrow;
                     w_err_nxt   = 1'b0;
                     w_state_nxt = ST_DONE;
                  end
                  OP_MUL: begin
                     w_state_nxt = ST_MUL;
                  end
                  OP_ILL: begin
                     w_load      = 1'b1;
                     w_res_nxt   = {(2*DATA_W){1'b0}};
                     w_carry_nxt = 1'b0;
                     w_err_nxt   = 1'b1;
                     w_state_nxt = ST_DONE;
                  end
                  default: begin
                     w_state_nxt = ST_IDLE;
                  end
               endcase
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (w_mul_done) begin
               w_load      = 1'b1;
               w_res_nxt   = w_mul_res;
               w_carry_nxt = w_mul_ovf;
               w_err_nxt   = 1'b0;
               w_state_nxt = ST_DONE;
            end else if (!w_mul_busy) begin
               // Multiplier idle without finishing: recover instead of hanging.
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_MUL;
            end
         end
         ST_DONE: begin
            if (i_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers; results only change on a load.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_result <= {(2*DATA_W){1'b0}};
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_result <= w_res_nxt;
            r_carry  <= w_carry_nxt;
            r_zero   <= (w_res_nxt == {(2*DATA_W){1'b0}});
            r_err    <= w_err_nxt;
         end else begin
            r_result <= r_result;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Directed self-checking bench for seq_alu_unit (DATA_W=8).
module tb_seq_alu_unit;

   logic        clk;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [1:0]  i_op;
   logic [7:0]  i_value_a;
   logic [7:0]  i_value_b;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_result;
   logic        o_carry;
   logic        o_zero;
   logic        o_err;

   int n_checks = 0;
   int n_fail   = 0;
   int lat;

`ifdef SEQ_ALU_SAT_EN
   localparam logic [15:0] EXP_ADD_OVF = 16'h00FF;
   localparam logic [15:0] EXP_SUB_BRW = 16'h0000;
   localparam logic [15:0] EXP_MUL_BIG = 16'h00FF;
`else
   localparam logic [15:0] EXP_ADD_OVF = 16'h012C;
   localparam logic [15:0] EXP_SUB_BRW = 16'h00FB;
   localparam logic [15:0] EXP_MUL_BIG = 16'hFE01;
`endif

   seq_alu_unit #(.DATA_W(8)) dut (
      .i_clk     (clk),
      .i_rst_n   (i_rst_n),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_op      (i_op),
      .i_value_a (i_value_a),
      .i_value_b (i_value_b),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_result  (o_result),
      .o_carry   (o_carry),
      .o_zero    (o_zero),
      .o_err     (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request before a rising edge, then scramble the inputs after acceptance.
   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      check("ready_before_accept", {31'd0, o_ready}, 32'd1);
      i_valid   = 1'b1;
      i_op      = op;
      i_value_a = a;
      i_value_b = b;
      @(posedge clk);
      #1;
      i_valid   = 1'b0;
      i_op      = 2'b00;
      i_value_a = 8'hAA;
      i_value_b = 8'h55;
   endtask

   // Cycles from the accept cycle until o_valid is seen (1 = valid right after accept edge).
   task automatic wait_valid(output int cycles);
      cycles = 1;
      while (!o_valid && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic release_result(input logic [15:0] held);
      @(negedge clk);
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_ready = 1'b0;
      check("valid_drops_on_release", {31'd0, o_valid}, 32'd0);
      check("ready_after_release", {31'd0, o_ready}, 32'd1);
      check("result_kept_after_release", {16'd0, o_result}, {16'd0, held});
   endtask

   initial begin
      i_rst_n   = 1'b0;
      i_valid   = 1'b0;
      i_ready   = 1'b0;
      i_op      = 2'b00;
      i_value_a = 8'd0;
      i_value_b = 8'd0;
      #2;
      check("reset_valid", {31'd0, o_valid}, 32'd0);
      check("reset_result", {16'd0, o_result}, 32'd0);
      check("reset_flags", {29'd0, o_carry, o_zero, o_err}, 32'd0);
      repeat (2) @(negedge clk);
      i_rst_n = 1'b1;
      #1;
      check("ready_out_of_reset", {31'd0, o_ready}, 32'd1);

      // ADD 200+100
      issue(2'b00, 8'd200, 8'd100);
      check("ready_low_after_accept", {31'd0, o_ready}, 32'd0);
      wait_valid(lat);
      check("add_latency", lat, 32'd1);
      check("add_result", {16'd0, o_result}, {16'd0, EXP_ADD_OVF});
      check("add_carry", {31'd0, o_carry}, 32'd1);
      check("add_zero", {31'd0, o_zero}, 32'd0);
      release_result(EXP_ADD_OVF);

      // SUB 5-10 (borrow)
      issue(2'b01, 8'd5, 8'd10);
      wait_valid(lat);
      check("sub_latency", lat, 32'd1);
      check("sub_borrow_result", {16'd0, o_result}, {16'd0, EXP_SUB_BRW});
      check("sub_borrow_carry", {31'd0, o_carry}, 32'd1);
`ifdef SEQ_ALU_SAT_EN
      check("sub_borrow_zero", {31'd0, o_zero}, 32'd1);
`else
      check("sub_borrow_zero", {31'd0, o_zero}, 32'd0);
`endif
      release_result(EXP_SUB_BRW);

      // SUB 200-55, no borrow
      issue(2'b01, 8'd200, 8'd55);
      wait_valid(lat);
      check("sub_result", {16'd0, o_result}, 32'h0091);
      check("sub_carry", {31'd0, o_carry}, 32'd0);
      release_result(16'h0091);

      // MUL 255*255
      issue(2'b10, 8'd255, 8'd255);
      wait_valid(lat);
      check("mul_big_latency", lat, 32'd9);
      check("mul_big_result", {16'd0, o_result}, {16'd0, EXP_MUL_BIG});
      check("mul_big_carry", {31'd0, o_carry}, 32'd1);
      check("mul_big_err", {31'd0, o_err}, 32'd0);
      release_result(EXP_MUL_BIG);

      // MUL 0*77: full latency, zero flag
      issue(2'b10, 8'd0, 8'd77);
      wait_valid(lat);
      check("mul_zero_latency", lat, 32'd9);
      check("mul_zero_result", {16'd0, o_result}, 32'd0);
      check("mul_zero_flag", {31'd0, o_zero}, 32'd1);
      check("mul_zero_carry", {31'd0, o_carry}, 32'd0);
      release_result(16'h0000);

      // MUL 12*13, no upper half
      issue(2'b10, 8'd12, 8'd13);
      wait_valid(lat);
      check("mul_small_result", {16'd0, o_result}, 32'h009C);
      check("mul_small_carry", {31'd0, o_carry}, 32'd0);
      release_result(16'h009C);

      // Backpressure: ADD 3+4 held for 5 cycles
      issue(2'b00, 8'd3, 8'd4);
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_result", {16'd0, o_result}, 32'h0007);
         check("bp_valid", {31'd0, o_valid}, 32'd1);
         check("bp_ready", {31'd0, o_ready}, 32'd0);
      end
      release_result(16'h0007);
      issue(2'b00, 8'd50, 8'd60);
      wait_valid(lat);
      check("post_bp_latency", lat, 32'd1);
      check("post_bp_result", {16'd0, o_result}, 32'h006E);
      release_result(16'h006E);

      // Reset in the middle of a multiply
      issue(2'b10, 8'd255, 8'd255);
      repeat (3) @(posedge clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("midreset_valid", {31'd0, o_valid}, 32'd0);
      check("midreset_result", {16'd0, o_result}, 32'd0);
      check("midreset_flags", {29'd0, o_carry, o_zero, o_err}, 32'd0);
      @(negedge clk);
      i_rst_n = 1'b1;
      #1;
      check("midreset_ready", {31'd0, o_ready}, 32'd1);
      issue(2'b00, 8'd1, 8'd1);
      wait_valid(lat);
      check("after_reset_add", {16'd0, o_result}, 32'h0002);
      check("after_reset_carry", {31'd0, o_carry}, 32'd0);
      release_result(16'h0002);

      // Illegal opcode
      issue(2'b11, 8'd9, 8'd9);
      wait_valid(lat);
      check("ill_latency", lat, 32'd1);
      check("ill_err", {31'd0, o_err}, 32'd1);
      check("ill_result", {16'd0, o_result}, 32'd0);
      check("ill_zero", {31'd0, o_zero}, 32'd1);
      check("ill_carry", {31'd0, o_carry}, 32'd0);
      release_result(16'h0000);
      issue(2'b00, 8'd10, 8'd20);
      wait_valid(lat);
      check("legal_after_ill_err", {31'd0, o_err}, 32'd0);
      check("legal_after_ill_result", {16'd0, o_result}, 32'h001E);
      check("legal_after_ill_zero", {31'd0, o_zero}, 32'd0);
      release_result(16'h001E);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
